// File: rtl/spi_rd.sv
// spi_rd: three-wire SPI read master; sends R/W=1 + 13-bit address, turns SDIO around, shifts in one byte.
module spi_rd #(
  parameter int SCLK_HALF = 1,
  parameter int CSB_SETUP = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [12:0] addr,
  output logic [7:0]  data_out,
  output logic        valid,
  output logic        busy,
  output logic        csb,
  output logic        sclk,
  output logic        sdio_o,
  output logic        sdio_oe,
  input  logic        sdio_i
);
  localparam int MX = SCLK_HALF > CSB_SETUP ? SCLK_HALF : CSB_SETUP;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, SETUP, INSTR, DATA} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] bc, bc_n;
  logic [15:0] sr, sr_n;
  logic [7:0] data_n;
  logic valid_n, busy_n, csb_n, sclk_n, sdio_o_n, sdio_oe_n;
  logic tick, rise, fall;
  assign tick = cnt == '0;
  assign rise = tick && !sclk;
  assign fall = tick && sclk;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bc <= '0;
      sr <= '0;
      data_out <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      csb <= 1'b1;
      sclk <= 1'b0;
      sdio_o <= 1'b0;
      sdio_oe <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bc <= bc_n;
      sr <= sr_n;
      data_out <= data_n;
      valid <= valid_n;
      busy <= busy_n;
      csb <= csb_n;
      sclk <= sclk_n;
      sdio_o <= sdio_o_n;
      sdio_oe <= sdio_oe_n;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rd_en ? SETUP : IDLE;
      SETUP:   state_n = tick ? INSTR : SETUP;
      INSTR:   state_n = fall && bc == 5'd15 ? DATA : INSTR;
      default: state_n = fall && bc == 5'd23 ? IDLE : DATA;
    endcase
  end
  // sr shifts the instruction out of its MSB, then the read byte into its LSB
  always_comb begin
    cnt_n = cnt;
    bc_n = bc;
    sr_n = sr;
    data_n = data_out;
    valid_n = 1'b0;
    busy_n = busy;
    csb_n = csb;
    sclk_n = sclk;
    sdio_o_n = sdio_o;
    sdio_oe_n = sdio_oe;
    case (state)
      IDLE: begin
        if (rd_en) begin
          sr_n = {3'b100, addr};
          cnt_n = CW'(CSB_SETUP - 1);
          bc_n = '0;
          busy_n = 1'b1;
        end
      end
      SETUP: begin
        cnt_n = tick ? CW'(SCLK_HALF - 1) : cnt - 1'b1;
        if (tick) begin
          csb_n = 1'b0;
          sdio_oe_n = 1'b1;
          sdio_o_n = sr[15];
        end
      end
      default: begin
        cnt_n = tick ? CW'(SCLK_HALF - 1) : cnt - 1'b1;
        if (rise) begin
          sclk_n = 1'b1;
          if (state == DATA) sr_n = {sr[14:0], sdio_i};
        end
        if (fall) begin
          sclk_n = 1'b0;
          bc_n = bc + 5'd1;
          if (state == INSTR) begin
            sr_n = {sr[14:0], 1'b0};
            sdio_o_n = bc == 5'd15 ? 1'b0 : sr[14];
            sdio_oe_n = bc != 5'd15;
          end else if (bc == 5'd23) begin
            csb_n = 1'b1;
            data_n = sr[7:0];
            valid_n = 1'b1;
            busy_n = 1'b0;
          end
        end
      end
    endcase
  end
endmodule
